// File: rtl/f_fetch_stage.sv
// f_fetch_stage: F stage of the P7 pipeline.
// Holds the architectural fetch PC, flags fetch address errors (AdEL) and
// owns the F/D pipeline register that hands PC, instruction, excode and the
// delay-slot flag to D.
// Optional build macro: FETCH_PERF_CNT_EN adds the fetched-instruction and
// stall-cycle counters; without it both perf outputs are constant zero.
module f_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFF,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        enter_handler,
  input  logic        db,
  input  logic        eret_d,
  input  logic [31:0] im_instr,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_excode,
  output logic        d_bd,
  output logic        d_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  // Fetch PC register and its next value.
  logic [31:0] pc_q, pc_d;
  logic        pc_load;

  // F/D pipeline register fields.
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [4:0]  d_excode_q, d_excode_d;
  logic        d_bd_q, d_bd_d;
  logic        d_valid_q, d_valid_d;

  // Fetch address error on the current PC: misaligned or outside IM.
  logic        adel;

  // Exception entry overrides a hazard stall so the handler PC is taken.
  assign pc_load = enter_handler | ~stall;

  // Unsigned range check; npc is used as-is, no alignment masking.
  assign adel = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_LIMIT);

  // Next fetch PC: load npc on a load cycle, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (pc_load) begin
      pc_d = npc;
    end
  end

  // Next F/D contents in priority order: flush, stall, eret squash, load.
  always_comb begin
    d_pc_d     = d_pc_q;
    d_instr_d  = d_instr_q;
    d_excode_d = d_excode_q;
    d_bd_d     = d_bd_q;
    d_valid_d  = d_valid_q;
    if (enter_handler) begin
      d_pc_d     = HANDLER_PC;
      d_instr_d  = 32'd0;
      d_excode_d = 5'd0;
      d_bd_d     = 1'b0;
      d_valid_d  = 1'b0;
    end else if (stall) begin
      // Hold every D field; eret_d and db are don't-care while stalled.
    end else if (eret_d) begin
      d_pc_d     = pc_q;
      d_instr_d  = 32'd0;
      d_excode_d = 5'd0;
      d_bd_d     = 1'b0;
      d_valid_d  = 1'b0;
    end else begin
      // A faulting fetch still carries its delay-slot flag so EPC is right.
      d_pc_d    = pc_q;
      d_bd_d    = db;
      d_valid_d = 1'b1;
      if (adel) begin
        d_instr_d  = 32'd0;
        d_excode_d = EXC_ADEL;
      end else begin
        d_instr_d  = im_instr;
        d_excode_d = 5'd0;
      end
    end
  end

  // PC and F/D state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      d_pc_q     <= RESET_PC;
      d_instr_q  <= 32'd0;
      d_excode_q <= 5'd0;
      d_bd_q     <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      d_pc_q     <= d_pc_d;
      d_instr_q  <= d_instr_d;
      d_excode_q <= d_excode_d;
      d_bd_q     <= d_bd_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign f_pc     = pc_q;
  assign d_pc     = d_pc_q;
  assign d_instr  = d_instr_q;
  assign d_excode = d_excode_q;
  assign d_bd     = d_bd_q;
  assign d_valid  = d_valid_q;

`ifdef FETCH_PERF_CNT_EN
  // Performance counters; both wrap naturally and only reset clears them.
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic        fetch_event;
  logic        stall_event;

  // A fetch is counted on every normal F/D load, faulting or not.
  assign fetch_event = ~enter_handler & ~stall & ~eret_d;
  assign stall_event = stall & ~enter_handler;

  // Next counter values.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (fetch_event) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (stall_event) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stalls_q  <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed vector table, randomized run against a
// reference model, and asynchronous reset checks mid-stall / mid-flush.
module tb_f_fetch_stage;

  localparam int W = 167;
  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HDL_PC  = 32'h0000_4180;
  localparam logic [4:0]  ADEL_EC = 5'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] npc, im_instr;
  logic        stall, enter_handler, db, eret_d;
  logic [31:0] f_pc, d_pc, d_instr, perf_fetched, perf_stalls;
  logic [4:0]  d_excode;
  logic        d_bd, d_valid;

  f_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .npc           (npc),
    .stall         (stall),
    .enter_handler (enter_handler),
    .db            (db),
    .eret_d        (eret_d),
    .im_instr      (im_instr),
    .f_pc          (f_pc),
    .d_pc          (d_pc),
    .d_instr       (d_instr),
    .d_excode      (d_excode),
    .d_bd          (d_bd),
    .d_valid       (d_valid),
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_fpc, m_dpc, m_dinstr, m_pf, m_ps;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;

  function automatic bit addr_err(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h0000_3000) || (a > 32'h0000_6FFF);
  endfunction

  task automatic model_reset();
    m_fpc = RST_PC; m_dpc = RST_PC; m_dinstr = 0; m_exc = 0;
    m_bd = 0; m_valid = 0; m_pf = 0; m_ps = 0;
  endtask

  // What one clock edge does, given the inputs currently applied.
  task automatic model_step();
    bit fault;
    fault = addr_err(m_fpc);
    if (enter_handler) begin
      m_dpc = HDL_PC; m_dinstr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
    end else if (!stall) begin
      m_dpc = m_fpc;
      if (eret_d) begin
        m_dinstr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else begin
        m_bd = db; m_valid = 1;
        m_dinstr = fault ? 32'd0 : im_instr;
        m_exc    = fault ? ADEL_EC : 5'd0;
`ifdef FETCH_PERF_CNT_EN
        m_pf = m_pf + 1;
`endif
      end
    end
`ifdef FETCH_PERF_CNT_EN
    if (stall && !enter_handler) m_ps = m_ps + 1;
`endif
    if (enter_handler || !stall) m_fpc = npc;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack_model();
    return {m_fpc, m_dpc, m_dinstr, m_exc, m_bd, m_valid, m_pf, m_ps};
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_sb(input string name);
    logic [W-1:0] want, got;
    got  = {f_pc, d_pc, d_instr, d_excode, d_bd, d_valid, perf_fetched, perf_stalls};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_f_pc"},    f_pc, RST_PC);
    check32({tag, "_d_pc"},    d_pc, RST_PC);
    check32({tag, "_d_instr"}, d_instr, 32'd0);
    check32({tag, "_d_exc"},   {27'd0, d_excode}, 32'd0);
    check32({tag, "_d_bd"},    {31'd0, d_bd}, 32'd0);
    check32({tag, "_d_valid"}, {31'd0, d_valid}, 32'd0);
    check32({tag, "_pf"},      perf_fetched, 32'd0);
    check32({tag, "_ps"},      perf_stalls, 32'd0);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic drive(input logic [31:0] n, input logic s, input logic eh,
                       input logic b, input logic er, input logic [31:0] ins);
    npc = n; stall = s; enter_handler = eh; db = b; eret_d = er; im_instr = ins;
    model_step();
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] npc;
    logic        stall, eh, db, eret;
    logic [31:0] instr;
    logic [31:0] e_fpc, e_dpc, e_instr;
    logic [4:0]  e_exc;
    logic        e_bd, e_valid;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [31:0] n, input logic s, input logic eh,
                              input logic b, input logic er, input logic [31:0] ins,
                              input logic [31:0] fp, input logic [31:0] dp,
                              input logic [31:0] di, input logic [4:0] ex,
                              input logic bd, input logic v);
    vec_t r;
    r.npc = n; r.stall = s; r.eh = eh; r.db = b; r.eret = er; r.instr = ins;
    r.e_fpc = fp; r.e_dpc = dp; r.e_instr = di; r.e_exc = ex; r.e_bd = bd; r.e_valid = v;
    return r;
  endfunction

  logic [31:0] exp_pf_tab, exp_ps_tab, exp_ps_stall3;

  initial begin
    reset = 1'b1;
    npc = 0; stall = 0; enter_handler = 0; db = 0; eret_d = 0; im_instr = 0;
    model_reset();
`ifdef FETCH_PERF_CNT_EN
    exp_pf_tab = 32'd11; exp_ps_tab = 32'd4; exp_ps_stall3 = 32'd3;
`else
    exp_pf_tab = 32'd0;  exp_ps_tab = 32'd0; exp_ps_stall3 = 32'd0;
`endif

    //                npc         s  eh db er instr          f_pc         d_pc         d_instr      exc bd v
    vecs[0]  = mk(32'h3004, 0, 0, 0, 0, 32'h2408_0001, 32'h3004, 32'h3000, 32'h2408_0001, 0, 0, 1);
    vecs[1]  = mk(32'h3008, 0, 0, 0, 0, 32'h1111_1111, 32'h3008, 32'h3004, 32'h1111_1111, 0, 0, 1);
    vecs[2]  = mk(32'h300C, 0, 0, 1, 0, 32'h2222_2222, 32'h300C, 32'h3008, 32'h2222_2222, 0, 1, 1);
    vecs[3]  = mk(32'h3010, 0, 0, 0, 0, 32'h3333_3333, 32'h3010, 32'h300C, 32'h3333_3333, 0, 0, 1);
    vecs[4]  = mk(32'h3050, 1, 0, 1, 1, 32'h4444_4444, 32'h3010, 32'h300C, 32'h3333_3333, 0, 0, 1);
    vecs[5]  = mk(32'h3050, 1, 0, 0, 0, 32'h4444_4444, 32'h3010, 32'h300C, 32'h3333_3333, 0, 0, 1);
    vecs[6]  = mk(32'h3050, 1, 0, 1, 0, 32'h4444_4444, 32'h3010, 32'h300C, 32'h3333_3333, 0, 0, 1);
    vecs[7]  = mk(32'h3002, 0, 0, 0, 0, 32'h5555_5555, 32'h3002, 32'h3010, 32'h5555_5555, 0, 0, 1);
    vecs[8]  = mk(32'h7000, 0, 0, 0, 0, 32'h6666_6666, 32'h7000, 32'h3002, 32'h0000_0000, 4, 0, 1);
    vecs[9]  = mk(32'h6FFC, 0, 0, 0, 0, 32'h6666_6666, 32'h6FFC, 32'h7000, 32'h0000_0000, 4, 0, 1);
    vecs[10] = mk(32'h2FFC, 0, 0, 1, 0, 32'h7777_7777, 32'h2FFC, 32'h6FFC, 32'h7777_7777, 0, 1, 1);
    vecs[11] = mk(32'h3000, 0, 0, 1, 0, 32'h7777_7777, 32'h3000, 32'h2FFC, 32'h0000_0000, 4, 1, 1);
    vecs[12] = mk(32'h4180, 1, 1, 1, 0, 32'h8888_0000, 32'h4180, 32'h4180, 32'h0000_0000, 0, 0, 0);
    vecs[13] = mk(32'h3020, 0, 0, 0, 0, 32'h8888_8888, 32'h3020, 32'h4180, 32'h8888_8888, 0, 0, 1);
    vecs[14] = mk(32'h3100, 0, 0, 1, 1, 32'h9999_9999, 32'h3100, 32'h3020, 32'h0000_0000, 0, 0, 0);
    vecs[15] = mk(32'h3200, 1, 0, 1, 1, 32'h9999_9999, 32'h3100, 32'h3020, 32'h0000_0000, 0, 0, 0);
    vecs[16] = mk(32'h3104, 0, 0, 0, 0, 32'hAAAA_0000, 32'h3104, 32'h3100, 32'hAAAA_0000, 0, 0, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].npc, vecs[i].stall, vecs[i].eh, vecs[i].db, vecs[i].eret, vecs[i].instr);
      check32($sformatf("v%0d_f_pc", i),    f_pc, vecs[i].e_fpc);
      check32($sformatf("v%0d_d_pc", i),    d_pc, vecs[i].e_dpc);
      check32($sformatf("v%0d_d_instr", i), d_instr, vecs[i].e_instr);
      check32($sformatf("v%0d_d_exc", i),   {27'd0, d_excode}, {27'd0, vecs[i].e_exc});
      check32($sformatf("v%0d_d_bd", i),    {31'd0, d_bd}, {31'd0, vecs[i].e_bd});
      check32($sformatf("v%0d_d_valid", i), {31'd0, d_valid}, {31'd0, vecs[i].e_valid});
      check_sb($sformatf("v%0d_model", i));
      if (i == 6) check32("stall3_perf_stalls", perf_stalls, exp_ps_stall3);
    end
    check32("tab_perf_fetched", perf_fetched, exp_pf_tab);
    check32("tab_perf_stalls",  perf_stalls,  exp_ps_tab);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] n;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      n = m_fpc + 32'd4;
      else if (sel < 8) n = {$urandom_range(32'h2FF0, 32'h7010)} & 32'hFFFF_FFFC;
      else if (sel < 9) n = {$urandom_range(32'h2FF0, 32'h7010)};
      else              n = $urandom;
      drive(n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom);
      check_sb($sformatf("rand%0d", i));
    end

    // Asynchronous reset while stalled, away from any clock edge.
    drive(32'h3ABC, 1, 0, 1, 0, 32'h1234_5678);
    check_sb("pre_rst_stall");
    stall = 1'b1; enter_handler = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("arst_stall");
    @(posedge clk);
    #1;
    check_reset_vals("arst_hold");
    reset = 1'b0;
    model_reset();

    drive(32'h3004, 0, 0, 0, 0, 32'h2408_0001);
    check_sb("post_rst0");
    drive(32'h3008, 0, 0, 0, 0, 32'h2408_0002);
    check_sb("post_rst1");

    // Asynchronous reset while an exception flush is being requested.
    stall = 1'b1; enter_handler = 1'b1; npc = 32'h4180;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("arst_flush");
    @(posedge clk);
    #1;
    check_reset_vals("arst_flush_hold");
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      drive(m_fpc + 32'd4, ($urandom_range(0, 3) == 0), 1'b0, $urandom_range(0, 1), 1'b0, $urandom);
      check_sb($sformatf("tail%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
